// File: rtl/mt_pkg.sv
// ----------------------------------------------------------------------------
// mt_pkg
// Shared types and helpers for the multithreaded core's switch-on-miss
// scheduler.
//   thread_state_t : per-thread readiness (READY / WAITING on a D-cache miss)
// sched_state_t    : scheduler phase (RUN / SWITCH / IDLE)
//   DEFAULT_TID_WIDTH : thread ID width for the default two-thread build
//   bootPc()       : reset resume PC of a thread (base + t*stride)
// ----------------------------------------------------------------------------
package mt_pkg;

   typedef enum logic {
      READY   = 1'b0,
      WAITING = 1'b1
   } thread_state_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SWITCH = 2'd1,
      IDLE   = 2'd2
   } sched_state_t;

   localparam int DEFAULT_TID_WIDTH = 1;

   // Each thread boots from its own slice of the address space so that the
   // threads never start on top of each other.
   function automatic logic [31:0] bootPc(input logic [31:0] base,
                                          input logic [31:0] stride,
                                          input int unsigned t);
      return base + stride * t;
   endfunction

endpackage

// File: rtl/mt_rr_picker.sv
// ----------------------------------------------------------------------------
// mt_rr_picker
// Combinational round-robin search for the next ready thread.
//   ready_i   : one bit per thread, 1 = may run
//   start_i   : search origin
//   exclude_i : 0 -> search start_i, start_i+1, ... (all threads)
//               1 -> search start_i+1, start_i+2, ... and skip start_i itself
//   found_o   : some thread in the searched window is ready
//   tid_o     : first ready thread in search order (0 when none found)
// ----------------------------------------------------------------------------
module mt_rr_picker #(
   parameter int NUM_THREADS = 2,
   parameter int TID_WIDTH   = 1
) (
   input  logic [NUM_THREADS-1:0] ready_i,
   input  logic [TID_WIDTH-1:0]   start_i,
   input  logic                   exclude_i,
   output logic                   found_o,
   output logic [TID_WIDTH-1:0]   tid_o
);

   // Walk the search order from the far end back towards the origin so that
   // the last hit written is the nearest one; that avoids needing a break.
   // With exclude_i the window is shifted by one and shortened by one, so the
   // origin thread (the one that just missed) is never chosen.
   always_comb begin
      int                   idx;
      logic [NUM_THREADS-1:0] shifted;
      found_o = 1'b0;
      tid_o   = '0;
      idx     = 0;
      shifted = '0;
      for (int i = NUM_THREADS - 1; i >= 0; i--) begin
         if (!(exclude_i && (i == NUM_THREADS - 1))) begin
            idx     = (int'(start_i) + i + int'(exclude_i)) % NUM_THREADS;
            shifted = ready_i >> idx;
            if (shifted[0]) begin
               found_o = 1'b1;
               tid_o   = TID_WIDTH'(idx);
            end
         end
      end
   end

endmodule

// File: rtl/mt_switch_scheduler.sv
// ----------------------------------------------------------------------------
// mt_switch_scheduler
// Coarse-grain switch-on-miss thread scheduler for the multithreaded 5-stage
// MIPS core. Tracks which thread owns fetch, which threads wait on a D-cache
// miss and where each thread resumes.
//   clk, rst                 : clock, synchronous active-high reset
//   miss_valid/tid/pc        : D-cache miss from the MEM stage (pc = replay)
//   fill_valid/tid           : miss resolved, thread may run again
//   active_tid               : thread currently owning fetch
//   redirect_valid/pc        : fetch loads redirect_pc at the next edge
//   fetch_stall              : hold fetch PC and i2d (no thread ready)
//   flush_i2d/d2e/e2m/m2w    : squash that pipeline register at next edge
//   switch_count             : completed thread switches (wraps)
// ----------------------------------------------------------------------------
module mt_switch_scheduler
   import mt_pkg::*;
#(
   parameter int          NUM_THREADS    = 2,
   parameter int          TID_WIDTH      = 1,
   parameter logic [31:0] BOOT_PC_BASE   = 32'h0000_0000,
   parameter logic [31:0] BOOT_PC_STRIDE = 32'h0001_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 miss_valid,
   input  logic [TID_WIDTH-1:0] miss_tid,
   input  logic [31:0]          miss_pc,
   input  logic                 fill_valid,
   input  logic [TID_WIDTH-1:0] fill_tid,
   output logic [TID_WIDTH-1:0] active_tid,
   output logic                 redirect_valid,
   output logic [31:0]          redirect_pc,
   output logic                 fetch_stall,
   output logic                 flush_i2d,
   output logic                 flush_d2e,
   output logic                 flush_e2m,
   output logic                 flush_m2w,
   output logic [31:0]          switch_count
);

   sched_state_t         state_q;
   logic [TID_WIDTH-1:0] activeTid_q;
   logic [TID_WIDTH-1:0] nextTid_q;
   thread_state_t        thread_q   [NUM_THREADS];
   logic [31:0]          resumePc_q [NUM_THREADS];
   logic [31:0]          switchCount_q;

   logic                   takeMiss;
   logic [NUM_THREADS-1:0] readyMask;
   logic                   pickFound;
   logic [TID_WIDTH-1:0]   pickTid;

   // Only a miss from the thread that owns fetch matters; a miss tagged with
   // another thread is left over from before the last switch and is dropped.
   assign takeMiss = (state_q == RUN) && miss_valid && (miss_tid == activeTid_q);

   // A fill arriving this cycle already counts as ready, so a thread can be
   // picked on the same edge its miss resolves instead of one cycle later.
   always_comb begin
      readyMask = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         readyMask[t] = (thread_q[t] == READY) ||
                        (fill_valid && (int'(fill_tid) == t));
      end
   end

   // In RUN the search rotates from the thread after the one that missed;
   // in IDLE every thread is a candidate and the lowest index wins.
   mt_rr_picker #(
      .NUM_THREADS (NUM_THREADS),
      .TID_WIDTH   (TID_WIDTH)
   ) uPicker (
      .ready_i   (readyMask),
      .start_i   ((state_q == RUN) ? activeTid_q : '0),
      .exclude_i (state_q == RUN),
      .found_o   (pickFound),
      .tid_o     (pickTid)
   );

   // Pipeline controls. RUN flushes everything at once on a take-miss so the
   // missing load never writes back; SWITCH and IDLE keep i2d empty while
   // fetch is redirected or parked.
   always_comb begin
      active_tid     = activeTid_q;
      switch_count   = switchCount_q;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      fetch_stall    = 1'b0;
      flush_i2d      = 1'b0;
      flush_d2e      = 1'b0;
      flush_e2m      = 1'b0;
      flush_m2w      = 1'b0;
      case (state_q)
         RUN: begin
            if (takeMiss) begin
               flush_i2d = 1'b1;
               flush_d2e = 1'b1;
               flush_e2m = 1'b1;
               flush_m2w = 1'b1;
            end
         end
         SWITCH: begin
            redirect_valid = 1'b1;
            redirect_pc    = resumePc_q[nextTid_q];
            flush_i2d      = 1'b1;
         end
         IDLE: begin
            fetch_stall = 1'b1;
            flush_i2d   = 1'b1;
         end
         default: ;
      endcase
   end

   // Scheduler state. Fills are applied first so that a same-cycle miss on
   // the same thread (written later in this block) wins and leaves it WAITING.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         activeTid_q   <= '0;
         nextTid_q     <= '0;
         switchCount_q <= 32'h0;
         for (int t = 0; t < NUM_THREADS; t++) begin
            thread_q[t]   <= READY;
            resumePc_q[t] <= bootPc(BOOT_PC_BASE, BOOT_PC_STRIDE, t);
         end
      end else begin
         if (fill_valid) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
               if (int'(fill_tid) == t) begin
                  thread_q[t] <= READY;
               end
            end
         end
         case (state_q)
            RUN: begin
               if (takeMiss) begin
                  thread_q[activeTid_q]   <= WAITING;
                  resumePc_q[activeTid_q] <= miss_pc;
                  if (pickFound) begin
                     nextTid_q <= pickTid;
                     state_q   <= SWITCH;
                  end else begin
                     state_q   <= IDLE;
                  end
               end
            end
            SWITCH: begin
               activeTid_q   <= nextTid_q;
               switchCount_q <= switchCount_q + 32'd1;
               state_q       <= RUN;
            end
            IDLE: begin
               if (pickFound) begin
                  nextTid_q <= pickTid;
                  state_q   <= SWITCH;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_mt_switch_scheduler.sv
// ----------------------------------------------------------------------------
// tb_mt_switch_scheduler
// Directed bench for two scheduler builds side by side: a 2-thread core
// (dut0) and a 4-thread core (dut1). A thread-level model predicts every
// output each cycle; literal checks in the stimulus pin the model.
// ----------------------------------------------------------------------------
module tb_mt_switch_scheduler;

   localparam int S_RUN    = 0;
   localparam int S_SWITCH = 1;
   localparam int S_IDLE   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        missValid [2];
   logic [2:0]  missTid   [2];
   logic [31:0] missPc    [2];
   logic        fillValid [2];
   logic [2:0]  fillTid   [2];

   logic [0:0]  at0;
   logic [1:0]  at1;
   logic        rv0, rv1, fs0, fs1;
   logic [31:0] rpc0, rpc1, sc0, sc1;
   logic        fi0, fd0, fe0, fm0, fi1, fd1, fe1, fm1;

   int compared = 0;
   int failed   = 0;

   // Model state: thread-level view of the scheduler for each build.
   bit          modelOn = 1'b0;
   int          mState  [2];
   int          mActive [2];
   int          mNext   [2];
   bit          mWait   [2][8];
   logic [31:0] mPc     [2][8];
   logic [31:0] mCount  [2];

   always #5 clk = ~clk;

   mt_switch_scheduler #(.NUM_THREADS(2), .TID_WIDTH(1)) dut0 (
      .clk(clk), .rst(rst),
      .miss_valid(missValid[0]), .miss_tid(missTid[0][0:0]), .miss_pc(missPc[0]),
      .fill_valid(fillValid[0]), .fill_tid(fillTid[0][0:0]),
      .active_tid(at0), .redirect_valid(rv0), .redirect_pc(rpc0),
      .fetch_stall(fs0), .flush_i2d(fi0), .flush_d2e(fd0), .flush_e2m(fe0),
      .flush_m2w(fm0), .switch_count(sc0)
   );

   mt_switch_scheduler #(.NUM_THREADS(4), .TID_WIDTH(2)) dut1 (
      .clk(clk), .rst(rst),
      .miss_valid(missValid[1]), .miss_tid(missTid[1][1:0]), .miss_pc(missPc[1]),
      .fill_valid(fillValid[1]), .fill_tid(fillTid[1][1:0]),
      .active_tid(at1), .redirect_valid(rv1), .redirect_pc(rpc1),
      .fetch_stall(fs1), .flush_i2d(fi1), .flush_d2e(fd1), .flush_e2m(fe1),
      .flush_m2w(fm1), .switch_count(sc1)
   );

   function automatic int nThreads(input int d);
      return (d == 0) ? 2 : 4;
   endfunction

   function automatic bit readyNow(input int d, input int t);
      return !mWait[d][t] || (fillValid[d] && (int'(fillTid[d]) == t));
   endfunction

   function automatic bit takeNow(input int d);
      return (mState[d] == S_RUN) && missValid[d] && (int'(missTid[d]) == mActive[d]);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         failed++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input int d, input logic mv, input logic [2:0] mt,
                                input logic [31:0] mp, input logic fv,
                                input logic [2:0] ft);
      missValid[d] = mv;
      missTid[d]   = mt;
      missPc[d]    = mp;
      fillValid[d] = fv;
      fillTid[d]   = ft;
   endtask

   task automatic clearInputs();
      for (int d = 0; d < 2; d++) applyStimulus(d, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance the model by one edge using the spec's thread-level rules.
   task automatic modelStep(input int d);
      int n;
      int pick;
      bit take;
      bit rdy [8];
      n = nThreads(d);
      if (rst) begin
         mState[d]  = S_RUN;
         mActive[d] = 0;
         mNext[d]   = 0;
         mCount[d]  = 32'h0;
         for (int t = 0; t < 8; t++) begin
            mWait[d][t] = 1'b0;
            mPc[d][t]   = 32'(t * 65536);
         end
      end else begin
         for (int t = 0; t < 8; t++) rdy[t] = (t < n) && readyNow(d, t);
         take = takeNow(d);
         pick = -1;
         if (mState[d] == S_RUN && take) begin
            for (int k = 1; k < n; k++)
               if (pick < 0 && rdy[(mActive[d] + k) % n]) pick = (mActive[d] + k) % n;
         end else if (mState[d] == S_IDLE) begin
            for (int t = 0; t < n; t++)
               if (pick < 0 && rdy[t]) pick = t;
         end
         if (fillValid[d] && int'(fillTid[d]) < n) mWait[d][fillTid[d]] = 1'b0;
         case (mState[d])
            S_RUN: if (take) begin
               mWait[d][mActive[d]] = 1'b1;
               mPc[d][mActive[d]]   = missPc[d];
               if (pick >= 0) begin
                  mNext[d]  = pick;
                  mState[d] = S_SWITCH;
               end else begin
                  mState[d] = S_IDLE;
               end
            end
            S_SWITCH: begin
               mActive[d] = mNext[d];
               mCount[d]  = mCount[d] + 32'd1;
               mState[d]  = S_RUN;
            end
            default: if (pick >= 0) begin
               mNext[d]  = pick;
               mState[d] = S_SWITCH;
            end
         endcase
      end
   endtask

   task automatic compareDut(input int d, input logic [31:0] at, input logic rv,
                             input logic [31:0] rpc, input logic fs,
                             input logic [3:0] fl, input logic [31:0] sc);
      logic        eRv, eFs;
      logic [31:0] eRpc;
      logic [3:0]  eFl;
      eRv = 1'b0; eFs = 1'b0; eRpc = 32'h0; eFl = 4'h0;
      if (mState[d] == S_RUN) begin
         if (takeNow(d)) eFl = 4'hF;
      end else if (mState[d] == S_SWITCH) begin
         eRv  = 1'b1;
         eRpc = mPc[d][mNext[d]];
         eFl  = 4'b1000;
      end else begin
         eFs = 1'b1;
         eFl = 4'b1000;
      end
      checkOutput($sformatf("dut%0d active_tid", d), at, 32'(mActive[d]));
      checkOutput($sformatf("dut%0d redirect_valid", d), {31'h0, rv}, {31'h0, eRv});
      checkOutput($sformatf("dut%0d redirect_pc", d), rpc, eRpc);
      checkOutput($sformatf("dut%0d fetch_stall", d), {31'h0, fs}, {31'h0, eFs});
      checkOutput($sformatf("dut%0d flush i2d/d2e/e2m/m2w", d), {28'h0, fl}, {28'h0, eFl});
      checkOutput($sformatf("dut%0d switch_count", d), sc, mCount[d]);
   endtask

   // Model advances on the same edge as the DUTs.
   always @(posedge clk) begin
      modelStep(0);
      modelStep(1);
      modelOn = 1'b1;
   end

   // Every cycle out of reset, both builds are compared against the model.
   always @(negedge clk) begin
      if (modelOn && !rst) begin
         compareDut(0, {31'h0, at0}, rv0, rpc0, fs0, {fi0, fd0, fe0, fm0}, sc0);
         compareDut(1, {30'h0, at1}, rv1, rpc1, fs1, {fi1, fd1, fe1, fm1}, sc1);
      end
   end

   initial begin
      clearInputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      checkOutput("reset active_tid", {31'h0, at0}, 32'h0);
      checkOutput("reset flushes", {28'h0, fi0, fd0, fe0, fm0}, 32'h0);
      checkOutput("reset redirect_valid", {31'h0, rv0}, 32'h0);
      checkOutput("reset switch_count", sc0, 32'h0);

      // First miss on thread 0 hands fetch to thread 1 at its boot PC.
      applyStimulus(0, 1'b1, 3'd0, 32'h40, 1'b0, 3'd0);
      #1;
      checkOutput("take-miss flushes", {28'h0, fi0, fd0, fe0, fm0}, 32'hF);
      step(); clearInputs(); #1;
      checkOutput("switch redirect_valid", {31'h0, rv0}, 32'h1);
      checkOutput("switch redirect_pc t1 boot", rpc0, 32'h0001_0000);
      step(); #1;
      checkOutput("after switch active_tid", {31'h0, at0}, 32'h1);
      checkOutput("after switch count", sc0, 32'h1);

      // Stale miss for a thread that no longer owns fetch.
      applyStimulus(0, 1'b1, 3'd0, 32'h77, 1'b0, 3'd0);
      #1;
      checkOutput("stale miss flushes", {28'h0, fi0, fd0, fe0, fm0}, 32'h0);
      step(); clearInputs(); #1;
      checkOutput("stale miss count", sc0, 32'h1);
      checkOutput("stale miss redirect", {31'h0, rv0}, 32'h0);

      // Both threads waiting -> IDLE until thread 0 fills.
      applyStimulus(0, 1'b1, 3'd1, 32'h0001_0020, 1'b0, 3'd0);
      step(); clearInputs(); #1;
      checkOutput("idle fetch_stall", {31'h0, fs0}, 32'h1);
      step(); #1;
      checkOutput("idle held fetch_stall", {31'h0, fs0}, 32'h1);
      applyStimulus(0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd0);
      step(); clearInputs(); #1;
      checkOutput("idle exit redirect_pc", rpc0, 32'h40);
      step(); #1;
      checkOutput("idle exit active_tid", {31'h0, at0}, 32'h0);
      checkOutput("idle exit count", sc0, 32'h2);

      // Miss on t0 while t1 fills the same cycle: go straight to t1.
      applyStimulus(0, 1'b1, 3'd0, 32'h80, 1'b1, 3'd1);
      step(); clearInputs(); #1;
      checkOutput("same-cycle fill redirect_pc", rpc0, 32'h0001_0020);
      checkOutput("same-cycle fill no stall", {31'h0, fs0}, 32'h0);
      step(); #1;
      checkOutput("same-cycle fill count", sc0, 32'h3);

      // Miss and fill on the same thread: miss wins, thread stays waiting.
      applyStimulus(0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd0);
      step(); clearInputs();
      applyStimulus(0, 1'b1, 3'd1, 32'h0001_0040, 1'b1, 3'd1);
      step(); clearInputs(); #1;
      checkOutput("miss-wins redirect_pc", rpc0, 32'h80);
      step();
      applyStimulus(0, 1'b1, 3'd0, 32'hC0, 1'b0, 3'd0);
      step(); clearInputs(); #1;
      checkOutput("miss-wins thread still waiting", {31'h0, fs0}, 32'h1);
      applyStimulus(0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd1);
      step(); clearInputs(); #1;
      checkOutput("miss-wins replay pc", rpc0, 32'h0001_0040);

      // Reset while in SWITCH discards everything.
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checkOutput("mid-switch reset active_tid", {31'h0, at0}, 32'h0);
      checkOutput("mid-switch reset redirect_valid", {31'h0, rv0}, 32'h0);
      checkOutput("mid-switch reset count", sc0, 32'h0);
      applyStimulus(0, 1'b1, 3'd0, 32'h44, 1'b0, 3'd0);
      step(); clearInputs(); #1;
      checkOutput("boot pc restored", rpc0, 32'h0001_0000);
      step();

      // Four-thread round robin.
      applyStimulus(1, 1'b1, 3'd0, 32'h100, 1'b0, 3'd0);
      step(); clearInputs(); #1;
      checkOutput("rr4 first pick t1", rpc1, 32'h0001_0000);
      step();
      applyStimulus(1, 1'b1, 3'd1, 32'h0001_0100, 1'b0, 3'd0);
      step(); clearInputs(); #1;
      checkOutput("rr4 pick t2", rpc1, 32'h0002_0000);
      step(); #1;
      checkOutput("rr4 active t2", {30'h0, at1}, 32'h2);
      applyStimulus(1, 1'b0, 3'd0, 32'h0, 1'b1, 3'd1);
      step(); clearInputs();
      applyStimulus(1, 1'b1, 3'd2, 32'h0002_0200, 1'b0, 3'd0);
      step(); clearInputs(); #1;
      checkOutput("rr4 after t2 pick t3", rpc1, 32'h0003_0000);
      step(); #1;
      checkOutput("rr4 active t3", {30'h0, at1}, 32'h3);
      applyStimulus(1, 1'b0, 3'd0, 32'h0, 1'b1, 3'd0);
      step(); clearInputs();
      applyStimulus(1, 1'b1, 3'd3, 32'h0003_0300, 1'b0, 3'd0);
      step(); clearInputs(); #1;
      checkOutput("rr4 wrap pick t0", rpc1, 32'h100);
      step(); #1;
      checkOutput("rr4 wrap active t0", {30'h0, at1}, 32'h0);
      checkOutput("rr4 switch_count", sc1, 32'h4);

      step();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule

// File: doc/mt_switch_scheduler.md
Name: mt_switch_scheduler

Overview:
- Coarse-grain, switch-on-miss thread scheduler for the multithreaded 5-stage MIPS core.
- Owns the active thread ID and each thread's ready/waiting state and resume PC.
- Drives the flush controls of the four pipeline registers (i2d, d2e, e2m, m2w), redirects fetch to the next ready thread, and stalls fetch when no thread is ready.

Parameters:
- NUM_THREADS, 2, number of hardware threads (2..8).
- TID_WIDTH, 1, thread ID width; must equal ceil(log2(NUM_THREADS)), minimum 1.
- BOOT_PC_BASE, 32'h0000_0000, resume PC of thread 0 at reset.
- BOOT_PC_STRIDE, 32'h0001_0000, reset resume PC of thread t is BOOT_PC_BASE + t*STRIDE.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- miss_valid  in  1  D-cache miss reported by the MEM-stage instruction this cycle
- miss_tid  in  TID_WIDTH  thread of the missing instruction
- miss_pc  in  32  PC of the missing instruction (the replay point)
- fill_valid  in  1  miss resolved; the thread may run again
- fill_tid  in  TID_WIDTH  thread whose miss resolved
- active_tid  out  TID_WIDTH  thread currently owning fetch
- redirect_valid  out  1  fetch loads redirect_pc at the next edge
- redirect_pc  out  32  resume PC of the incoming thread
- fetch_stall  out  1  hold the fetch PC and the i2d register
- flush_i2d, flush_d2e, flush_e2m, flush_m2w  out  1 each  squash the corresponding pipeline register at the next edge
- switch_count  out  32  number of completed thread switches

Behaviour:
- Reset, synchronous, at a clk edge with rst=1:
  - state=RUN, active_tid=0, all threads READY.
  - resume_pc[t]=BOOT_PC_BASE+t*BOOT_PC_STRIDE.
  - switch_count=0, next_tid=0.
  - All outputs are 0 except active_tid=0.
  - rst mid-switch or while IDLE discards all pending state.
- States: RUN, SWITCH, IDLE.
- RUN:
  - A take-miss occurs when miss_valid=1 and miss_tid==active_tid.
  - On a take-miss, in the same cycle and combinationally: all four flush_* =1. The missing instruction and every younger instruction are squashed; m2w is flushed so the missing load never writes back.
  - At the edge after a take-miss:
    - thread[active_tid] becomes WAITING and resume_pc[active_tid] <= miss_pc.
    - The picker searches round-robin starting at active_tid+1 (wrapping modulo NUM_THREADS, active thread excluded).
    - If a READY thread is found: next_tid <= it, go to SWITCH.
    - If none is found: go to IDLE.
  - Readiness for the search includes a fill arriving in the same cycle.
  - miss_valid with miss_tid != active_tid is stale and ignored.
- SWITCH, exactly 1 cycle:
  - Outputs: redirect_valid=1, redirect_pc=resume_pc[next_tid], flush_i2d=1, fetch_stall=0.
  - At the edge: active_tid <= next_tid, switch_count += 1 (wraps at 2^32), go to RUN.
  - Misses are ignored in this state.
- IDLE:
  - Outputs: fetch_stall=1, flush_i2d=1, redirect_valid=0.
  - When any thread is READY (including a same-cycle fill): next_tid <= lowest-index ready thread, go to SWITCH.
- Fill:
  - At the edge, thread[fill_tid] <= READY.
  - A fill for an already-READY thread is ignored; a fill_tid >= NUM_THREADS is ignored.
  - Same-cycle take-miss and fill with the same tid: the miss wins and the thread ends WAITING.
- Invariants:
  - active_tid is never WAITING while in RUN.
  - Flush outputs are combinational from inputs in RUN and registered-state driven in SWITCH/IDLE.
  - No flush is asserted in RUN without a take-miss.
- Latency: miss to first fetch of the new thread = 2 edges (miss edge, SWITCH edge).

Decomposition:
- Package mt_pkg:
  - thread_state_t {READY, WAITING}
  - sched_state_t {RUN, SWITCH, IDLE}
  - TID_WIDTH default
  - the boot PC helper function
- Sub-module mt_rr_picker: combinational. Inputs: ready mask, start index, exclude-index enable. Outputs: found, tid. Used in both RUN (rotating start) and IDLE (start 0).

Test Plan:
- Reset:
  - assert rst 2 cycles -> active_tid=0, all flush_*=0, redirect_valid=0, switch_count=0.
  - then miss tid0 pc=0x40 -> flushes=1 that cycle; next cycle SWITCH, redirect_pc=0x0001_0000; then active_tid=1, switch_count=1.
- Both threads miss (NUM_THREADS=2):
  - tid0 miss pc=0x40, then tid1 miss pc=0x10020 -> IDLE, fetch_stall=1.
  - fill tid0 -> SWITCH, redirect_pc=0x40, active_tid=0.
- Stale miss: miss_valid with miss_tid=1 while active_tid=0 -> no flush, state stays RUN, switch_count unchanged.
- Simultaneous miss and fill:
  - same tid0 -> tid0 WAITING, tid1 selected.
  - fill tid1 same cycle as tid0 miss while tid1 WAITING -> SWITCH to tid1 (no IDLE).
- Round-robin with NUM_THREADS=4 (TID_WIDTH=2):
  - threads 1,2,3 READY, active 2 misses -> next_tid=3.
  - then 3 misses with 0,1 READY -> next_tid=0.
- Reset mid-SWITCH: rst during SWITCH -> next cycle active_tid=0, redirect_valid=0, all threads READY, resume_pc restored to boot values.
